// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared fetch FSM encoding and default widths.  Rev 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      OP_ADDR  = 3'd0,
      OP_DATA  = 3'd1,
      ARG_ADDR = 3'd2,
      ARG_DATA = 3'd3,
      VALID    = 3'd4
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_reg : program counter with load, wrap-around increment and reset.  Rev 1.0
// ---------------------------------------------------------------------------
module pc_reg #(
   parameter int                    addr_width = 8,
   parameter logic [addr_width-1:0] reset_addr = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [addr_width-1:0] load_addr,
   input  logic                  inc,
   output logic [addr_width-1:0] pc
);

   logic [addr_width-1:0] pc_d;
   logic [addr_width-1:0] pc_q;

   // Load beats increment; the add wraps naturally at the top address.
   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_addr;
      end else if (inc) begin
         pc_d = pc_q + addr_width'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= reset_addr;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : two-byte instruction fetch from a synchronous RAM with a
// valid/ready output.  Optional FETCH_HALT_EN adds a halt input.  Rev 1.0
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    addr_width = DEF_ADDR_WIDTH,
   parameter int                    data_width = DEF_DATA_WIDTH,
   parameter logic [addr_width-1:0] reset_addr = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef FETCH_HALT_EN
   input  logic                  halt,
`endif
   output logic [addr_width-1:0] ram_addr,
   input  logic [data_width-1:0] ram_dout,
   input  logic                  jmp_en,
   input  logic [addr_width-1:0] jmp_addr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [data_width-1:0] opcode,
   output logic [data_width-1:0] operand,
   output logic [addr_width-1:0] instr_pc
);

   fetch_state_e          state_d, state_q;
   logic [data_width-1:0] opcode_d, opcode_q;
   logic [data_width-1:0] operand_d, operand_q;
   logic [addr_width-1:0] instr_pc_d, instr_pc_q;
   logic [addr_width-1:0] pc;
   logic                  pc_inc;
   logic                  pc_load;
   logic                  hold_fetch;

`ifdef FETCH_HALT_EN
   assign hold_fetch = halt;
`else
   assign hold_fetch = 1'b0;
`endif

   pc_reg #(
      .addr_width (addr_width),
      .reset_addr (reset_addr)
   ) u_pc_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (pc_load),
      .load_addr (jmp_addr),
      .inc       (pc_inc),
      .pc        (pc)
   );

   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      operand_d  = operand_q;
      instr_pc_d = instr_pc_q;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;

      unique case (state_q)
         OP_ADDR: begin
            if (!hold_fetch) begin
               state_d = OP_DATA;
            end
         end
         OP_DATA: begin
            opcode_d   = ram_dout;
            instr_pc_d = pc;
            pc_inc     = 1'b1;
            state_d    = ARG_ADDR;
         end
         ARG_ADDR: begin
            state_d = ARG_DATA;
         end
         ARG_DATA: begin
            operand_d = ram_dout;
            pc_inc    = 1'b1;
            state_d   = VALID;
         end
         VALID: begin
            if (instr_ready) begin
               state_d = OP_ADDR;
            end
         end
         default: begin
            state_d = OP_ADDR;
         end
      endcase

      // A jump abandons whatever was in flight and restarts at the target.
      if (jmp_en) begin
         state_d    = OP_ADDR;
         pc_load    = 1'b1;
         pc_inc     = 1'b0;
         opcode_d   = opcode_q;
         operand_d  = operand_q;
         instr_pc_d = instr_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= OP_ADDR;
         opcode_q   <= '0;
         operand_q  <= '0;
         instr_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         opcode_q   <= opcode_d;
         operand_q  <= operand_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   assign ram_addr    = pc;
   assign instr_valid = (state_q == VALID);
   assign opcode      = opcode_q;
   assign operand     = operand_q;
   assign instr_pc    = instr_pc_q;

endmodule
`default_nettype wire
